// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared definitions for the multi-cycle MIPS control unit:
//               state encoding, opcode values, ALU operation encodings and
//               the instruction classes produced by the opcode decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // Controller states; the encoding is visible on the debug 'state' port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Primary opcode field values (inst[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation encodings driven on ALUOp.
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    // Instruction classes; each class shares one path through the FSM.
    typedef enum logic [2:0] {
        CLS_NOP    = 3'd0,
        CLS_RTYPE  = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_IMM    = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_JUMP   = 3'd6
    } instr_class_t;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_decode
// Description : Purely combinational opcode decoder. Maps the latched opcode
//               to an instruction class and to the ALU operation used in EXEC.
//               Unrecognised opcodes decode as CLS_NOP.
// Ports       : opcode      in  6  latched instruction opcode
//               instr_class out 3  instruction class (instr_class_t encoding)
//               alu_op      out 3  ALU operation for the EXEC step
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [2:0] instr_class,
    output logic [2:0] alu_op
);

    always_comb begin
        instr_class = CLS_NOP;
        alu_op      = ALUOP_ADD;
        case (opcode)
            OP_RTYPE: begin
                instr_class = CLS_RTYPE;
                alu_op      = ALUOP_FUNCT;
            end
            OP_LW:   instr_class = CLS_LOAD;
            OP_SW:   instr_class = CLS_STORE;
            OP_ADDI: instr_class = CLS_IMM;
            OP_BEQ, OP_BNE: begin
                instr_class = CLS_BRANCH;
                alu_op      = ALUOP_SUB;
            end
            OP_J:    instr_class = CLS_JUMP;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_ctrl
// Description : Multi-cycle MIPS control unit. Steps each instruction through
//               FETCH/DECODE/EXEC/MEM/WB, drives the datapath strobes and
//               issues the one-cycle IF advance pulse (with Branch/Jump) to
//               the program counter in each instruction's completion cycle.
//               Runs while 'over'=1 and halts when the PC reports 'sortover'.
// Config      : define PERF_CNT_EN to add the instr_cnt/cycle_cnt counters.
// Ports       : Clk, Clr (async, active-low)        clock / reset
//               over, sortover, inst[31:0]           run enable, finish, IMEM
//               IF, Branch, Jump                     PC handshake
//               IRWrite, RegDst, ALUSrc, MemtoReg,
//               RegWrite, MemRead, MemWrite, ALUOp   datapath controls
//               state[2:0], done                     debug state / finished
//               instr_cnt, cycle_cnt                 (PERF_CNT_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        over,
    input  logic        sortover,
    input  logic [31:0] inst,
    output logic        IF,
    output logic        Branch,
    output logic        Jump,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  ALUOp,
    output logic [2:0]  state,
    output logic        done
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] cycle_cnt
`endif
);

    state_t       state_q, state_d;
    logic [5:0]   opcode_q, opcode_d;
    logic [2:0]   dec_class;
    logic [2:0]   dec_alu_op;
    instr_class_t cls;

    // Only the opcode field is used; the rest belongs to the datapath.
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst[25:0];

    mc_ctrl_decode u_decode (
        .opcode      (opcode_q),
        .instr_class (dec_class),
        .alu_op      (dec_alu_op)
    );

    assign cls   = instr_class_t'(dec_class);
    assign state = state_q;

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        IF       = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUOp    = ALUOP_ADD;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (over && !sortover) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // A finished program halts here without loading another word.
                if (sortover) begin
                    state_d = ST_HALT;
                end else begin
                    IRWrite  = 1'b1;
                    opcode_d = inst[31:26];
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (cls)
                    CLS_JUMP: begin
                        IF      = 1'b1;
                        Jump    = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CLS_NOP: begin
                        IF      = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                ALUOp = dec_alu_op;
                case (cls)
                    CLS_LOAD, CLS_STORE: begin
                        ALUSrc  = 1'b1;
                        state_d = ST_MEM;
                    end
                    CLS_IMM: begin
                        ALUSrc  = 1'b1;
                        state_d = ST_WB;
                    end
                    CLS_RTYPE: state_d = ST_WB;
                    CLS_BRANCH: begin
                        // The PC resolves taken/not-taken from its own compare.
                        IF      = 1'b1;
                        Branch  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                case (cls)
                    CLS_LOAD: begin
                        MemRead = 1'b1;
                        state_d = ST_WB;
                    end
                    CLS_STORE: begin
                        MemWrite = 1'b1;
                        IF       = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_WB: begin
                RegWrite = 1'b1;
                RegDst   = (cls == CLS_RTYPE);
                MemtoReg = (cls == CLS_LOAD);
                IF       = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_HALT: begin
                done = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping 'over' aborts in step with the PC clearing itself; this
        // cycle's outputs still reflect the current state.
        if (!over && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

`ifdef PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        if ((state_q == ST_IDLE) && (state_d == ST_FETCH)) begin
            // Each run starts counting afresh.
            instr_cnt_d = '0;
            cycle_cnt_d = '0;
        end else begin
            if (IF && (instr_cnt_q != CNT_MAX))
                instr_cnt_d = instr_cnt_q + 1'b1;
            if ((state_q != ST_IDLE) && (state_q != ST_HALT) && (cycle_cnt_q != CNT_MAX))
                cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_ctrl
// Description : Self-checking bench for multi_cycle_ctrl. A table of per-cycle
//               {inputs, expected outputs} records walks a program through the
//               controller; hand-written sequences cover reset, halt, abort
//               on 'over' loss, mid-instruction reset and the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_ctrl;

    localparam int CNT_W = 16;

    // Strobe masks: {IF,Branch,Jump,IRWrite,RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite}
    localparam logic [9:0] S_NONE = 10'b0000000000;
    localparam logic [9:0] S_IF   = 10'b1000000000;
    localparam logic [9:0] S_BR   = 10'b0100000000;
    localparam logic [9:0] S_JP   = 10'b0010000000;
    localparam logic [9:0] S_IRW  = 10'b0001000000;
    localparam logic [9:0] S_RD   = 10'b0000100000;
    localparam logic [9:0] S_AS   = 10'b0000010000;
    localparam logic [9:0] S_M2R  = 10'b0000001000;
    localparam logic [9:0] S_RW   = 10'b0000000100;
    localparam logic [9:0] S_MR   = 10'b0000000010;
    localparam logic [9:0] S_MW   = 10'b0000000001;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HALT = 3'd6;

    localparam logic [31:0] I_LW   = 32'h8C010000;
    localparam logic [31:0] I_SW   = 32'hAC010004;
    localparam logic [31:0] I_R    = 32'h00221820;
    localparam logic [31:0] I_ADDI = 32'h20010005;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_J    = 32'h08000000;
    localparam logic [31:0] I_UNK  = 32'hFC000000;

    logic        Clk = 1'b0;
    logic        Clr, over, sortover;
    logic [31:0] inst;
    logic        IF, Branch, Jump, IRWrite, RegDst, ALUSrc, MemtoReg;
    logic        RegWrite, MemRead, MemWrite, done;
    logic [2:0]  ALUOp, state;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] instr_cnt, cycle_cnt;
`endif

    multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
        .Clk      (Clk),
        .Clr      (Clr),
        .over     (over),
        .sortover (sortover),
        .inst     (inst),
        .IF       (IF),
        .Branch   (Branch),
        .Jump     (Jump),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .ALUSrc   (ALUSrc),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ALUOp    (ALUOp),
        .state    (state),
        .done     (done)
`ifdef PERF_CNT_EN
        ,
        .instr_cnt (instr_cnt),
        .cycle_cnt (cycle_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        over;
        logic        sortover;
        logic [31:0] inst;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl [25];
    int   n_vec    = 0;
    int   n_cmp    = 0;
    int   n_fail   = 0;
    logic prev_if  = 1'b0;

    function automatic logic [16:0] eo(input logic [2:0] st, input logic [9:0] s,
                                       input logic [2:0] aop, input logic dn);
        return {s, aop, st, dn};
    endfunction

    function automatic logic [16:0] act();
        return {IF, Branch, Jump, IRWrite, RegDst, ALUSrc, MemtoReg, RegWrite,
                MemRead, MemWrite, ALUOp, state, done};
    endfunction

    task automatic add(input logic ov, input logic so, input logic [31:0] in,
                       input logic [16:0] e);
        tbl[n_vec] = '{over: ov, sortover: so, inst: in, exp: e};
        n_vec++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs plus handshake invariants,
    // then advance to 1 ns after the next rising edge.
    task automatic cyc(input string name, input logic ov, input logic so,
                       input logic [31:0] in, input logic [16:0] e);
        over = ov; sortover = so; inst = in;
        #1;
        chk(name, {15'd0, act()}, {15'd0, e});
        chk({name, "_inv"},
            {29'd0, IF & prev_if, Branch & Jump, (Branch | Jump) & ~IF}, 32'd0);
        prev_if = IF;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Clr = 1'b0; over = 1'b0; sortover = 1'b0; inst = '0;

        // ---- table: lw, sw, R, addi, beq, j, unknown -----------------------
        add(1, 0, I_LW,   eo(IDLE,   S_NONE, 3'b000, 0));
        add(1, 0, I_LW,   eo(FETCH,  S_IRW, 3'b000, 0));
        add(1, 0, I_LW,   eo(DECODE, S_NONE, 3'b000, 0));
        add(1, 0, I_LW,   eo(EXEC,   S_AS, 3'b000, 0));
        add(1, 0, I_LW,   eo(MEM,    S_MR, 3'b000, 0));
        add(1, 0, I_LW,   eo(WB,     S_RW | S_M2R | S_IF, 3'b000, 0));
        add(1, 0, I_SW,   eo(FETCH,  S_IRW, 3'b000, 0));
        add(1, 0, I_SW,   eo(DECODE, S_NONE, 3'b000, 0));
        add(1, 0, I_SW,   eo(EXEC,   S_AS, 3'b000, 0));
        add(1, 0, I_SW,   eo(MEM,    S_MW | S_IF, 3'b000, 0));
        add(1, 0, I_R,    eo(FETCH,  S_IRW, 3'b000, 0));
        add(1, 0, I_R,    eo(DECODE, S_NONE, 3'b000, 0));
        add(1, 0, I_R,    eo(EXEC,   S_NONE, 3'b010, 0));
        add(1, 0, I_R,    eo(WB,     S_RW | S_RD | S_IF, 3'b000, 0));
        add(1, 0, I_ADDI, eo(FETCH,  S_IRW, 3'b000, 0));
        add(1, 0, I_ADDI, eo(DECODE, S_NONE, 3'b000, 0));
        add(1, 0, I_ADDI, eo(EXEC,   S_AS, 3'b000, 0));
        add(1, 0, I_ADDI, eo(WB,     S_RW | S_IF, 3'b000, 0));
        add(1, 0, I_BEQ,  eo(FETCH,  S_IRW, 3'b000, 0));
        add(1, 0, I_BEQ,  eo(DECODE, S_NONE, 3'b000, 0));
        add(1, 0, I_BEQ,  eo(EXEC,   S_IF | S_BR, 3'b001, 0));
        add(1, 0, I_J,    eo(FETCH,  S_IRW, 3'b000, 0));
        add(1, 0, I_J,    eo(DECODE, S_IF | S_JP, 3'b000, 0));
        add(1, 0, I_UNK,  eo(FETCH,  S_IRW, 3'b000, 0));
        add(1, 0, I_UNK,  eo(DECODE, S_IF, 3'b000, 0));

        // ---- reset held 3 cycles with over=0 -------------------------------
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_hold", {15'd0, act()}, {15'd0, eo(IDLE, S_NONE, 3'b000, 0)});
        Clr = 1'b1;
        cyc("idle_over0_a", 0, 0, I_LW, eo(IDLE, S_NONE, 3'b000, 0));
        cyc("idle_over0_b", 0, 0, I_LW, eo(IDLE, S_NONE, 3'b000, 0));

        for (int i = 0; i < n_vec; i++)
            cyc($sformatf("vec%0d", i), tbl[i].over, tbl[i].sortover, tbl[i].inst, tbl[i].exp);

        // ---- sortover arrives with the IF pulse -> HALT, then over=0 -------
        cyc("halt_fetch_j",  1, 0, I_J, eo(FETCH,  S_IRW, 3'b000, 0));
        cyc("halt_jump_if",  1, 1, I_J, eo(DECODE, S_IF | S_JP, 3'b000, 0));
        cyc("halt_no_irw",   1, 1, I_J, eo(FETCH,  S_NONE, 3'b000, 0));
        cyc("halt_done",     1, 1, I_J, eo(HALT,   S_NONE, 3'b000, 1));
        cyc("halt_hold",     1, 0, I_J, eo(HALT,   S_NONE, 3'b000, 1));
        cyc("halt_exit",     0, 0, I_J, eo(HALT,   S_NONE, 3'b000, 1));
        cyc("halt_to_idle",  0, 0, I_J, eo(IDLE,   S_NONE, 3'b000, 0));

        // ---- over dropped during MEM of lw: abort, no WB -------------------
        cyc("abort_idle",    1, 0, I_LW, eo(IDLE,   S_NONE, 3'b000, 0));
        cyc("abort_fetch",   1, 0, I_LW, eo(FETCH,  S_IRW, 3'b000, 0));
        cyc("abort_decode",  1, 0, I_LW, eo(DECODE, S_NONE, 3'b000, 0));
        cyc("abort_exec",    1, 0, I_LW, eo(EXEC,   S_AS, 3'b000, 0));
        cyc("abort_mem",     0, 0, I_LW, eo(MEM,    S_MR, 3'b000, 0));
        cyc("abort_no_wb",   0, 0, I_LW, eo(IDLE,   S_NONE, 3'b000, 0));

        // ---- Clr asserted during EXEC: immediate IDLE, restart via FETCH ---
        cyc("clr_idle",      1, 0, I_LW, eo(IDLE,   S_NONE, 3'b000, 0));
        cyc("clr_fetch",     1, 0, I_LW, eo(FETCH,  S_IRW, 3'b000, 0));
        cyc("clr_decode",    1, 0, I_LW, eo(DECODE, S_NONE, 3'b000, 0));
        over = 1'b1;
        #1;
        chk("clr_pre_exec", {15'd0, act()}, {15'd0, eo(EXEC, S_AS, 3'b000, 0)});
        Clr = 1'b0;
        #1;
        chk("clr_async", {15'd0, act()}, {15'd0, eo(IDLE, S_NONE, 3'b000, 0)});
        @(posedge Clk);
        #1;
        Clr = 1'b1;
        prev_if = 1'b0;
        cyc("clr_rel_idle",  1, 0, I_LW, eo(IDLE,   S_NONE, 3'b000, 0));
        cyc("clr_restart",   1, 0, I_LW, eo(FETCH,  S_IRW, 3'b000, 0));

`ifdef PERF_CNT_EN
        // ---- counters over three R-type instructions from a fresh start ----
        cyc("perf_stop",     0, 0, I_R, eo(DECODE, S_NONE, 3'b000, 0));
        cyc("perf_idle",     1, 0, I_R, eo(IDLE,   S_NONE, 3'b000, 0));
        for (int k = 0; k < 3; k++) begin
            cyc($sformatf("perf_r%0d_f", k), 1, 0, I_R, eo(FETCH,  S_IRW, 3'b000, 0));
            cyc($sformatf("perf_r%0d_d", k), 1, 0, I_R, eo(DECODE, S_NONE, 3'b000, 0));
            cyc($sformatf("perf_r%0d_e", k), 1, 0, I_R, eo(EXEC,   S_NONE, 3'b010, 0));
            cyc($sformatf("perf_r%0d_w", k), 1, 0, I_R, eo(WB,     S_RW | S_RD | S_IF, 3'b000, 0));
        end
        chk("perf_instr_cnt", {16'd0, instr_cnt}, 32'd3);
        chk("perf_cycle_cnt", {16'd0, cycle_cnt}, 32'd12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
